// File: rtl/output_port_allocator.sv
// ---------------------------------------------------------------------------
// output_port_allocator
//
// Purpose:
//   Output-side allocator of a mesh NoC router, one instance per output port.
//   Collects the port-request bit that each input's LBDR unit raises for this
//   output and arbitrates between the five inputs (0=N 1=E 2=W 3=S 4=L).
//   The winner keeps the output (wormhole lock) from its HEADER flit through
//   its TAIL flit. Downstream buffer space is tracked with credits.
//
// Ports:
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   req        in   5       req[i]   = input i requests this output
//   empty      in   5       empty[i] = input i FIFO is empty
//   flit_id    in   15      flit_id[3i+2:3i] = id of input i's head flit
//   credit_in  in   1       one-cycle pulse: downstream freed one slot
//   grant      out  5       one-hot read grant / flit forward strobe
//   sel        out  3       crossbar select (owner index, 0 when idle)
//   valid_out  out  1       a flit goes downstream this cycle
//   busy       out  1       allocator is locked to an owner
//   credit_err out  1       sticky: credit returned while already full
//
// Configuration:
//   ARB_FIXED_PRIO_EN  when defined, round-robin arbitration is replaced by
//                      fixed priority L(4) > N(0) > E(1) > W(2) > S(3) and
//                      the round-robin pointer disappears.
// ---------------------------------------------------------------------------

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module output_port_allocator #(
   parameter int NUM_IN  = 5,
   parameter int CREDITS = 4,
   parameter int CNT_W   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_IN-1:0]     req,
   input  logic [NUM_IN-1:0]     empty,
   input  logic [3*NUM_IN-1:0]   flit_id,
   input  logic                  credit_in,
   output logic [NUM_IN-1:0]     grant,
   output logic [2:0]            sel,
   output logic                  valid_out,
   output logic                  busy,
   output logic                  credit_err
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [2:0]         owner;
   logic [2:0]         owner_next;
   logic [CNT_W-1:0]   credit_cnt;
   logic [NUM_IN-1:0]  cand;
   logic               any_cand;
   logic [2:0]         winner;
   logic [2:0]         owner_flit;
   logic               owner_empty;
   logic               grant_now;
   logic               tail_done;
   logic [2:0]         owner_plus1;

   // An input is a candidate only when it presents a header flit for us.
   always_comb begin
      cand = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         cand[i] = req[i] & ~empty[i] & (flit_id[3*i +: 3] == `HEADER);
      end
   end

   assign any_cand = |cand;

`ifdef ARB_FIXED_PRIO_EN
   // Fixed priority: local port first, then N, E, W, S.
   always_comb begin
      winner = 3'd0;
      if (cand[4])      winner = 3'd4;
      else if (cand[0]) winner = 3'd0;
      else if (cand[1]) winner = 3'd1;
      else if (cand[2]) winner = 3'd2;
      else if (cand[3]) winner = 3'd3;
   end
`else
   logic [2:0] rr_ptr;
   logic [2:0] rr_next;
   logic       found;
   logic [3:0] idx;

   // Round-robin: scan from rr_ptr upwards (mod 5), first candidate wins.
   always_comb begin
      winner = 3'd0;
      found  = 1'b0;
      idx    = 4'd0;
      for (int k = 0; k < NUM_IN; k++) begin
         idx = {1'b0, rr_ptr} + 4'(k);
         if (idx >= 4'(NUM_IN)) begin
            idx = idx - 4'(NUM_IN);
         end
         if (!found && cand[idx[2:0]]) begin
            found  = 1'b1;
            winner = idx[2:0];
         end
      end
   end

   // The pointer moves past the owner only when its packet completes, so
   // the owner loses priority for the following round.
   always_comb begin
      rr_next = rr_ptr;
      if (tail_done) begin
         rr_next = owner_plus1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= 3'd0;
      end else begin
         rr_ptr <= rr_next;
      end
   end
`endif

   // Mux out the owner's FIFO status and head flit id.
   always_comb begin
      owner_flit  = 3'd0;
      owner_empty = 1'b1;
      for (int i = 0; i < NUM_IN; i++) begin
         if (owner == 3'(i)) begin
            owner_flit  = flit_id[3*i +: 3];
            owner_empty = empty[i];
         end
      end
   end

   assign owner_plus1 = (owner == 3'(NUM_IN - 1)) ? 3'd0 : owner + 3'd1;

   // The grant is suppressed during the reset cycle so an aborted packet
   // never pops a flit it can no longer forward.
   assign grant_now = (state == LOCKED) & ~owner_empty
                      & (credit_cnt != '0) & ~rst;
   assign tail_done = grant_now & (owner_flit == `TAIL);

   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         grant[i] = grant_now & (owner == 3'(i));
      end
   end

   assign valid_out = grant_now;
   assign busy      = (state == LOCKED);
   assign sel       = (state == LOCKED) ? owner : 3'd0;

   // Lock FSM: IDLE arbitrates, LOCKED forwards until the TAIL is granted.
   always_comb begin
      state_next = state;
      owner_next = owner;
      case (state)
         IDLE: begin
            if (any_cand) begin
               state_next = LOCKED;
               owner_next = winner;
            end
         end
         LOCKED: begin
            if (tail_done) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= 3'd0;
      end else begin
         state <= state_next;
         owner <= owner_next;
      end
   end

   // Credit counter: a grant consumes a slot, a credit pulse returns one.
   // A return while already full is a protocol error and is latched.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_cnt <= CNT_W'(CREDITS);
         credit_err <= 1'b0;
      end else begin
         if (grant_now && !credit_in) begin
            credit_cnt <= credit_cnt - 1'b1;
         end else if (credit_in && !grant_now
                      && credit_cnt != CNT_W'(CREDITS)) begin
            credit_cnt <= credit_cnt + 1'b1;
         end
         if (credit_in && credit_cnt == CNT_W'(CREDITS)) begin
            credit_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_output_port_allocator.sv
// ---------------------------------------------------------------------------
// tb_output_port_allocator
//
// Purpose:
//   Self-checking bench for output_port_allocator. Five upstream FIFOs are
//   modelled as packet arrays; a behavioural allocator model predicts every
//   output each cycle. Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module tb_output_port_allocator;

   localparam int CREDITS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  req;
   logic [4:0]  empty;
   logic [14:0] flit_id;
   logic        credit_in;
   logic [4:0]  grant;
   logic [2:0]  sel;
   logic        valid_out;
   logic        busy;
   logic        credit_err;

   output_port_allocator #(.NUM_IN(5), .CREDITS(CREDITS), .CNT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .empty      (empty),
      .flit_id    (flit_id),
      .credit_in  (credit_in),
      .grant      (grant),
      .sel        (sel),
      .valid_out  (valid_out),
      .busy       (busy),
      .credit_err (credit_err)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // Upstream FIFO contents
   logic [2:0] fifo [5][256];
   int         rd [5];
   int         wr [5];
   logic [4:0] stall;
   logic [4:0] req_en;
   int         ds_occ;

   // Reference model state
   bit m_locked;
   int m_owner;
   int m_rr;
   int m_cred;
   bit m_err;

   // Observations from the DUT for directed sequence checks
   int owner_log [$];
   int grants_seen;
   bit prev_busy;

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit q_empty(input int i);
      return rd[i] == wr[i];
   endfunction

   function automatic logic [2:0] q_head(input int i);
      return fifo[i][rd[i] % 256];
   endfunction

   task automatic push_pkt(input int i, input int len);
      for (int k = 0; k < len; k++) begin
         fifo[i][wr[i] % 256] = (k == 0) ? `HEADER :
                                (k == len - 1) ? `TAIL : `PAYLOAD;
         wr[i]++;
      end
   endtask

   task automatic flush();
      for (int i = 0; i < 5; i++) rd[i] = wr[i];
   endtask

   // Arbitration rank: lower is better.
   function automatic int rank(input int i);
`ifdef ARB_FIXED_PRIO_EN
      return (i == 4) ? 0 : i + 1;
`else
      return (i - m_rr + 5) % 5;
`endif
   endfunction

   // One clock cycle: drive inputs, check predicted outputs, advance model.
   task automatic applyStimulus(input bit do_rst, input bit ci);
      logic [4:0] e_grant;
      bit         granted;
      int         best;
      rst       = do_rst;
      credit_in = ci;
      for (int i = 0; i < 5; i++) begin
         empty[i]           = q_empty(i) | stall[i];
         flit_id[3*i +: 3]  = q_empty(i) ? 3'b000 : q_head(i);
         req[i]             = ~q_empty(i) & req_en[i];
      end
      @(negedge clk);
      e_grant = '0;
      if (!do_rst && m_locked && !empty[m_owner] && m_cred > 0)
         e_grant[m_owner] = 1'b1;
      granted = (e_grant != 0);
      checkOutput(e_grant);
      if (busy && !prev_busy) owner_log.push_back(int'(sel));
      prev_busy = busy;
      if (valid_out) grants_seen++;
      @(posedge clk);
      if (do_rst) begin
         m_locked = 0; m_owner = 0; m_rr = 0; m_cred = CREDITS; m_err = 0;
         ds_occ = 0;
      end else begin
         if (m_locked) begin
            if (granted && q_head(m_owner) == `TAIL) begin
               m_locked = 0;
               m_rr     = (m_owner + 1) % 5;
            end
         end else begin
            best = -1;
            for (int i = 0; i < 5; i++) begin
               if (req[i] && !empty[i] && flit_id[3*i +: 3] == `HEADER)
                  if (best < 0 || rank(i) < rank(best)) best = i;
            end
            if (best >= 0) begin
               m_locked = 1;
               m_owner  = best;
            end
         end
         if (ci && m_cred == CREDITS) m_err = 1;
         m_cred = m_cred + int'(ci) - int'(granted);
         if (m_cred > CREDITS) m_cred = CREDITS;
         if (granted) begin
            rd[m_owner == -1 ? 0 : $clog2(int'(e_grant))]++;
            ds_occ++;
         end
         if (ci && ds_occ > 0) ds_occ--;
      end
      #1;
   endtask

   task automatic checkOutput(input logic [4:0] e_grant);
      check("grant",      int'(grant),      int'(e_grant));
      check("sel",        int'(sel),        m_locked ? m_owner : 0);
      check("busy",       int'(busy),       int'(m_locked));
      check("valid_out",  int'(valid_out),  int'(e_grant != 0));
      check("credit_err", int'(credit_err), int'(m_err));
   endtask

   function automatic bit legal_ci();
      return (ds_occ > 0) && ($urandom_range(1, 0) == 1);
   endfunction

   function automatic bit pending();
      bit p;
      p = m_locked;
      for (int i = 0; i < 5; i++) if (!q_empty(i)) p = 1;
      return p;
   endfunction

   task automatic drain(input string tag);
      int n;
      n = 0;
      stall  = '0;
      req_en = '1;
      while (pending() && n < 2000) begin
         applyStimulus(0, legal_ci());
         n++;
      end
      check(tag, int'(n >= 2000), 0);
   endtask

   int exp_seq [6];
   int g0;

   initial begin
      for (int i = 0; i < 5; i++) begin rd[i] = 0; wr[i] = 0; end
      stall = '0; req_en = '1; ds_occ = 0; prev_busy = 0; grants_seen = 0;
      m_locked = 0; m_owner = 0; m_rr = 0; m_cred = CREDITS; m_err = 0;
      rst = 1; req = '0; empty = '1; flit_id = '0; credit_in = 0;
      #1;

      // Reset, then one 3-flit packet from W with no returning credits.
      applyStimulus(1, 0);
      push_pkt(2, 3);
      g0 = grants_seen;
      for (int k = 0; k < 6; k++) applyStimulus(0, 0);
      check("t1_flits", grants_seen - g0, 3);
      check("t1_idle", int'(busy), 0);

      // One credit left: S packet stalls after one flit until a credit.
      push_pkt(3, 3);
      g0 = grants_seen;
      for (int k = 0; k < 5; k++) applyStimulus(0, 0);
      check("t3_first", grants_seen - g0, 1);
      check("t3_held", int'(busy), 1);
      applyStimulus(0, 1);
      g0 = grants_seen;
      for (int k = 0; k < 4; k++) applyStimulus(0, 0);
      check("t3_one_more", grants_seen - g0, 1);
      ds_occ = 5;
      drain("t3_drain");

      // All inputs contend with 2-flit packets; credit_in every cycle.
      applyStimulus(1, 0);
      owner_log.delete();
      for (int i = 0; i < 5; i++) for (int p = 0; p < 3; p++) push_pkt(i, 2);
      for (int k = 0; k < 40; k++) applyStimulus(0, 1);
`ifdef ARB_FIXED_PRIO_EN
      exp_seq = '{4, 4, 4, 0, 0, 0};
`else
      exp_seq = '{0, 1, 2, 3, 4, 0};
`endif
      check("t2_count", int'(owner_log.size() >= 6), 1);
      for (int k = 0; k < 6 && k < owner_log.size(); k++)
         check("t2_owner", owner_log[k], exp_seq[k]);
      drain("t2_drain");

      // Owner bubble while N waits with a header.
      applyStimulus(1, 0);
      owner_log.delete();
      push_pkt(1, 4);
      applyStimulus(0, 0);
      applyStimulus(0, 0);
      stall[1] = 1'b1;
      push_pkt(0, 2);
      for (int k = 0; k < 3; k++) applyStimulus(0, 0);
      check("t4_held", int'(busy), 1);
      check("t4_sel", int'(sel), 1);
      drain("t4_drain");
      check("t4_order_n", int'(owner_log.size()), 2);
      if (owner_log.size() == 2) begin
         check("t4_first", owner_log[0], 1);
         check("t4_second", owner_log[1], 0);
      end

      // Reset after one flit of a 4-flit packet.
      applyStimulus(1, 0);
      push_pkt(0, 4);
      applyStimulus(0, 0);
      applyStimulus(0, 0);
      applyStimulus(1, 0);
      flush();
      applyStimulus(0, 0);
      check("t5_busy", int'(busy), 0);
      push_pkt(2, 6);
      g0 = grants_seen;
      for (int k = 0; k < 8; k++) applyStimulus(0, 0);
      check("t5_full_credits", grants_seen - g0, CREDITS);
      flush();
      applyStimulus(1, 0);

      // Credit returned while already full.
      applyStimulus(0, 1);
      for (int k = 0; k < 3; k++) applyStimulus(0, 0);
      check("t6_err", int'(credit_err), 1);
      applyStimulus(1, 0);
      applyStimulus(0, 0);
      check("t6_cleared", int'(credit_err), 0);

      // Randomized traffic.
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(3, 0) == 0) begin
            int i;
            i = $urandom_range(4, 0);
            if (wr[i] - rd[i] < 12) push_pkt(i, $urandom_range(5, 2));
         end
         for (int i = 0; i < 5; i++) begin
            stall[i]  = ($urandom_range(3, 0) == 0);
            req_en[i] = ($urandom_range(5, 0) != 0);
         end
         applyStimulus(0, legal_ci());
      end
      drain("rand_drain");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
